// File: rtl/param_stream_tx.sv
// rtl/param_stream_tx.sv - framed byte-stream transmitter for the parameter pin protocol; optional checksum byte under PARAM_TX_CSUM_EN
module param_stream_tx #(
   parameter int unsigned GAP_CYCLES   = 1,
   parameter int unsigned BUSY_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a0,
   input  logic [31:0] a1,
   input  logic        core_busy,
   output logic [7:0]  data_pins,
   output logic [7:0]  ctrl_pins,
   output logic        busy,
   output logic        done,
   output logic        timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_SEND,
      S_GAP,
      S_FINISH
   } state_t;

`ifdef PARAM_TX_CSUM_EN
   localparam logic [3:0] LAST_IDX = 4'd8;
`else
   localparam logic [3:0] LAST_IDX = 4'd7;
`endif
   localparam logic [3:0]  GAP_LAST  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
   localparam logic [15:0] WAIT_LAST = 16'(BUSY_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [63:0] shadow_q, shadow_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [7:0]  data_q, data_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  cur_byte;

`ifdef PARAM_TX_CSUM_EN
   logic [7:0] csum;

   // Checksum byte is the XOR of the eight shadowed data bytes.
   always_comb begin
      csum = 8'h00;
      for (int i = 0; i < 8; i++) begin
         csum = csum ^ shadow_q[i*8 +: 8];
      end
   end

   // Byte for the current index: little-endian a0 then a1, checksum in the final slot.
   always_comb begin
      cur_byte = shadow_q[{idx_q[2:0], 3'b000} +: 8];
      if (idx_q == LAST_IDX) begin
         cur_byte = csum;
      end
   end
`else
   // Byte for the current index: little-endian a0 then a1.
   always_comb begin
      cur_byte = shadow_q[{idx_q[2:0], 3'b000} +: 8];
   end
`endif

   // Next-state and next-output logic; outputs are registered, so pins follow the state by one cycle.
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      idx_d      = idx_q;
      gap_cnt_d  = gap_cnt_q;
      wait_cnt_d = wait_cnt_q;
      data_d     = data_q;
      ctrl_d     = 3'b000;
      busy_d     = busy_q;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               shadow_d   = {a1, a0};
               busy_d     = 1'b1;
               idx_d      = 4'd0;
               wait_cnt_d = 16'd0;
               state_d    = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (!core_busy) begin
               state_d = S_SEND;
            end else if (wait_cnt_q == WAIT_LAST) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         S_SEND: begin
            data_d    = cur_byte;
            ctrl_d    = {idx_q == LAST_IDX, idx_q == 4'd0, 1'b1};
            gap_cnt_d = 4'd0;
            if (idx_q == LAST_IDX) begin
               state_d = S_FINISH;
            end else if (GAP_CYCLES == 0) begin
               idx_d = idx_q + 4'd1;
            end else begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               idx_d   = idx_q + 4'd1;
               state_d = S_SEND;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, shadow, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shadow_q   <= 64'd0;
         idx_q      <= 4'd0;
         gap_cnt_q  <= 4'd0;
         wait_cnt_q <= 16'd0;
         data_q     <= 8'd0;
         ctrl_q     <= 3'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         idx_q      <= idx_d;
         gap_cnt_q  <= gap_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         data_q     <= data_d;
         ctrl_q     <= ctrl_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   assign data_pins = data_q;
   assign ctrl_pins = {5'b00000, ctrl_q};
   assign busy      = busy_q;
   assign done      = done_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_param_stream_tx.sv
// tb/tb_param_stream_tx.sv - randomized self-checking bench for param_stream_tx
module tb_param_stream_tx;

`ifdef PARAM_TX_CSUM_EN
   localparam int N   = 9;
   localparam int GAP = 0;
`else
   localparam int N   = 8;
   localparam int GAP = 1;
`endif
   localparam int TMO  = 20;
   localparam int SETL = 12 + N * (GAP + 1);

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       sof;
      logic       eof;
   } ev_t;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        start     = 1'b0;
   logic        core_busy = 1'b0;
   logic [31:0] a0        = 32'd0;
   logic [31:0] a1        = 32'd0;
   logic [7:0]  data_pins;
   logic [7:0]  ctrl_pins;
   logic        busy;
   logic        done;
   logic        timeout;

   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   ev_t  evq[$];
   ev_t  expq[$];
   int   doneq[$];
   int   toq[$];
   ev_t  mon_ev;

   param_stream_tx #(
      .GAP_CYCLES  (GAP),
      .BUSY_TIMEOUT(TMO)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a0       (a0),
      .a1       (a1),
      .core_busy(core_busy),
      .data_pins(data_pins),
      .ctrl_pins(ctrl_pins),
      .busy     (busy),
      .done     (done),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver view: log every strobed byte, done and timeout with the edge count.
   always @(negedge clk) begin
      if (ctrl_pins[0] === 1'b1) begin
         mon_ev.cyc  = cyc;
         mon_ev.data = data_pins;
         mon_ev.sof  = ctrl_pins[1];
         mon_ev.eof  = ctrl_pins[2];
         evq.push_back(mon_ev);
      end
      if (done === 1'b1) doneq.push_back(cyc);
      if (timeout === 1'b1) toq.push_back(cyc);
   end

   // Expected frame: bytes of a0 then a1 LSB first, optional XOR checksum, one byte every GAP+1 cycles.
   function automatic void model_frame(input logic [31:0] x0, input logic [31:0] x1, input int t0);
      logic [7:0] b;
      logic [7:0] cs;
      ev_t        e;
      cs = 8'h00;
      for (int i = 0; i < N; i++) begin
         if (i < 8) begin
            b  = 8'(((i < 4) ? x0 : x1) >> (8 * (i % 4)));
            cs = cs ^ b;
         end else begin
            b = cs;
         end
         e.cyc  = t0 + i * (GAP + 1);
         e.data = b;
         e.sof  = (i == 0);
         e.eof  = (i == N - 1);
         expq.push_back(e);
      end
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      evq.delete();
      expq.delete();
      doneq.delete();
      toq.delete();
   endtask

   task automatic launch(input logic [31:0] x0, input logic [31:0] x1, input logic cb, output int s);
      a0        = x0;
      a1        = x1;
      core_busy = cb;
      start     = 1'b1;
      s         = cyc + 1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      a0    = $urandom;
      a1    = $urandom;
      tick(3);
      n_cmp++;
      if ({data_pins, ctrl_pins, busy, done, timeout} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got data=%h ctrl=%h busy=%b done=%b timeout=%b, want all 0",
                  data_pins, ctrl_pins, busy, done, timeout);
      end
      rst_n = 1'b1;
      start = 1'b0;
      clear_logs();
      tick(5);
      n_cmp++;
      if (evq.size() != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: got strobes=%0d busy=%b, want strobes=0 busy=0", evq.size(), busy);
      end
   endtask

   task automatic test_basic();
      int s;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] x0;
         logic [31:0] x1;
         x0 = $urandom;
         x1 = $urandom;
         if (k == 0) begin x0 = 32'h11223344; x1 = 32'hA5A50F0F; end
         if (k == 1) begin x0 = 32'h01020304; x1 = 32'h10203040; end
         clear_logs();
         launch(x0, x1, 1'b0, s);
         n_cmp++;
         if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy%0d: got busy=%b, want 1", k, busy);
         end
         a0 = $urandom;
         a1 = $urandom;
         tick(SETL);
         model_frame(x0, x1, s + 2);
         for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= evq.size()) begin
               n_bad++;
               $display("FAIL basic%0d_byte%0d: got no strobe, want data=%h at cycle %0d", k, i, expq[i].data, expq[i].cyc);
            end else if (evq[i].data !== expq[i].data || evq[i].cyc != expq[i].cyc ||
                         evq[i].sof !== expq[i].sof || evq[i].eof !== expq[i].eof) begin
               n_bad++;
               $display("FAIL basic%0d_byte%0d: got data=%h cyc=%0d sof=%b eof=%b, want data=%h cyc=%0d sof=%b eof=%b",
                        k, i, evq[i].data, evq[i].cyc, evq[i].sof, evq[i].eof,
                        expq[i].data, expq[i].cyc, expq[i].sof, expq[i].eof);
            end
         end
         n_cmp++;
         if (evq.size() != N || doneq.size() != 1 || doneq[0] != s + 3 + (N - 1) * (GAP + 1) || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic%0d_done: got strobes=%0d dones=%0d first_done=%0d busy=%b, want strobes=%0d dones=1 done=%0d busy=0",
                     k, evq.size(), doneq.size(), (doneq.size() > 0) ? doneq[0] : -1, busy,
                     N, s + 3 + (N - 1) * (GAP + 1));
         end
      end
   endtask

   task automatic test_busy_wait();
      int s;
      int f;
      for (int k = 0; k < 2; k++) begin
         logic [31:0] x0;
         logic [31:0] x1;
         int          b;
         x0 = $urandom;
         x1 = $urandom;
         b  = (k == 0) ? 10 : int'($urandom_range(1, 15));
         clear_logs();
         launch(x0, x1, 1'b1, s);
         tick(b);
         core_busy = 1'b0;
         f = cyc + 1;
         tick(SETL);
         model_frame(x0, x1, f + 1);
         for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (i >= evq.size()) begin
               n_bad++;
               $display("FAIL busywait%0d_byte%0d: got no strobe, want data=%h at cycle %0d", k, i, expq[i].data, expq[i].cyc);
            end else if (evq[i].data !== expq[i].data || evq[i].cyc != expq[i].cyc ||
                         evq[i].sof !== expq[i].sof || evq[i].eof !== expq[i].eof) begin
               n_bad++;
               $display("FAIL busywait%0d_byte%0d: got data=%h cyc=%0d sof=%b eof=%b, want data=%h cyc=%0d sof=%b eof=%b",
                        k, i, evq[i].data, evq[i].cyc, evq[i].sof, evq[i].eof,
                        expq[i].data, expq[i].cyc, expq[i].sof, expq[i].eof);
            end
         end
         n_cmp++;
         if (evq.size() != N || doneq.size() != 1 || toq.size() != 0) begin
            n_bad++;
            $display("FAIL busywait%0d_count: got strobes=%0d dones=%0d timeouts=%0d, want %0d/1/0",
                     k, evq.size(), doneq.size(), toq.size(), N);
         end
      end
   endtask

   task automatic test_timeout();
      int          s;
      logic [31:0] x0;
      logic [31:0] x1;
      clear_logs();
      launch($urandom, $urandom, 1'b1, s);
      tick(TMO + 5);
      n_cmp++;
      if (toq.size() != 1 || toq[0] != s + TMO) begin
         n_bad++;
         $display("FAIL timeout_pulse: got pulses=%0d at=%0d, want 1 at cycle %0d",
                  toq.size(), (toq.size() > 0) ? toq[0] : -1, s + TMO);
      end
      n_cmp++;
      if (evq.size() != 0 || doneq.size() != 0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_quiet: got strobes=%0d dones=%0d busy=%b, want 0/0/0", evq.size(), doneq.size(), busy);
      end
      x0 = $urandom;
      x1 = $urandom;
      clear_logs();
      launch(x0, x1, 1'b0, s);
      tick(SETL);
      model_frame(x0, x1, s + 2);
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (i >= evq.size()) begin
            n_bad++;
            $display("FAIL after_timeout_byte%0d: got no strobe, want data=%h", i, expq[i].data);
         end else if (evq[i].data !== expq[i].data || evq[i].cyc != expq[i].cyc ||
                      evq[i].sof !== expq[i].sof || evq[i].eof !== expq[i].eof) begin
            n_bad++;
            $display("FAIL after_timeout_byte%0d: got data=%h cyc=%0d, want data=%h cyc=%0d",
                     i, evq[i].data, evq[i].cyc, expq[i].data, expq[i].cyc);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xa0, xa1, xb0, xb1;
      int          s1, s2, d1;
      xa0 = $urandom;
      xa1 = $urandom;
      xb0 = $urandom;
      xb1 = $urandom;
      clear_logs();
      a0        = xa0;
      a1        = xa1;
      core_busy = 1'b0;
      start     = 1'b1;
      s1        = cyc + 1;
      tick(3);
      a0 = $urandom;
      a1 = $urandom;
      tick(3);
      a0 = xb0;
      a1 = xb1;
      d1 = s1 + 3 + (N - 1) * (GAP + 1);
      s2 = d1 + 1;
      while (cyc < s2) tick();
      start = 1'b0;
      a0    = $urandom;
      a1    = $urandom;
      tick(SETL);
      model_frame(xa0, xa1, s1 + 2);
      model_frame(xb0, xb1, s2 + 2);
      for (int i = 0; i < 2 * N; i++) begin
         n_cmp++;
         if (i >= evq.size()) begin
            n_bad++;
            $display("FAIL b2b_byte%0d: got no strobe, want data=%h at cycle %0d", i, expq[i].data, expq[i].cyc);
         end else if (evq[i].data !== expq[i].data || evq[i].cyc != expq[i].cyc ||
                      evq[i].sof !== expq[i].sof || evq[i].eof !== expq[i].eof) begin
            n_bad++;
            $display("FAIL b2b_byte%0d: got data=%h cyc=%0d sof=%b eof=%b, want data=%h cyc=%0d sof=%b eof=%b",
                     i, evq[i].data, evq[i].cyc, evq[i].sof, evq[i].eof,
                     expq[i].data, expq[i].cyc, expq[i].sof, expq[i].eof);
         end
      end
      n_cmp++;
      if (evq.size() != 2 * N || doneq.size() != 2 || doneq[0] != d1 || doneq[1] != s2 + 3 + (N - 1) * (GAP + 1)) begin
         n_bad++;
         $display("FAIL b2b_done: got strobes=%0d dones=%0d, want strobes=%0d dones at %0d and %0d",
                  evq.size(), doneq.size(), 2 * N, d1, s2 + 3 + (N - 1) * (GAP + 1));
      end
   endtask

   task automatic test_reset_midframe();
      int s;
      int waited;
      clear_logs();
      launch($urandom, $urandom, 1'b0, s);
      waited = 0;
      while (evq.size() < 5 && waited < 40) begin
         tick();
         waited++;
      end
      n_cmp++;
      if (evq.size() < 5) begin
         n_bad++;
         $display("FAIL midreset_reach: got strobes=%0d after %0d cycles, want 5", evq.size(), waited);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({data_pins, ctrl_pins, busy, done, timeout} !== 19'd0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got data=%h ctrl=%h busy=%b done=%b timeout=%b, want all 0",
                  data_pins, ctrl_pins, busy, done, timeout);
      end
      tick(2);
      rst_n = 1'b1;
      tick(SETL);
      n_cmp++;
      if (doneq.size() != 0 || evq.size() != 5 || evq[evq.size() - 1].eof !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_trunc: got dones=%0d strobes=%0d, want dones=0 strobes=5 without eof",
                  doneq.size(), evq.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy_wait();
      test_timeout();
      test_back_to_back();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/param_stream_tx.md
Name: param_stream_tx

Overview:
- Transmit end of the parameter pin protocol consumed by the chip's parameter loader.
- Takes two 32-bit signed parameters (a0, a1) and serialises them as a framed byte stream onto the 8-bit data pins and the 8-bit control pins.
- Used in the companion/test harness and in loopback benches.
- Waits for the core to be idle, paces bytes, and aborts on a stuck-busy condition (watchdog timeout).

Parameters:
- GAP_CYCLES, 1: idle cycles (strobe low) inserted between consecutive bytes; legal range 0..15.
- BUSY_TIMEOUT, 255: maximum cycles to wait for core_busy low before aborting; legal range 1..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to send one frame; sampled only in IDLE
- a0  input  32  first parameter, signed; captured on accepted start
- a1  input  32  second parameter, signed; captured on accepted start
- core_busy  input  1  high while the receiving core/loader cannot accept a frame
- data_pins  output  8  data byte (drives ui_in side)
- ctrl_pins  output  8  [0]=strobe, [1]=sof, [2]=eof, [7:3]=0 (drives uio side)
- busy  output  1  high from accepted start until return to IDLE
- done  output  1  1-cycle pulse after the last byte of a frame is sent
- timeout  output  1  1-cycle pulse when a frame is aborted by BUSY_TIMEOUT

Behaviour:
- Reset (async, rst_n low): all outputs 0, state IDLE, shadow registers 0, counters 0.
- States: IDLE, WAIT_RDY, SEND, GAP, FINISH.
- IDLE:
  - start=1 captures a0/a1 into shadow registers, sets busy, clears the byte index and wait counter, then goes to WAIT_RDY.
  - start is ignored in all other states. Inputs a0/a1 may change freely after capture.
- WAIT_RDY:
  - core_busy=0: go to SEND.
  - core_busy=1: increment the wait counter. When the counter reaches BUSY_TIMEOUT, pulse timeout, clear busy, and go to IDLE; no byte is emitted.
- SEND (one cycle per byte):
  - data_pins = shadow byte[idx]. Byte order: a0[7:0], a0[15:8], a0[23:16], a0[31:24], then a1 in the same order (idx 0..7).
  - strobe=1. sof=1 only when idx=0. eof=1 only on the final byte.
  - If more bytes remain: go to GAP, or stay in SEND if GAP_CYCLES=0.
  - After the final byte: go to FINISH.
- GAP:
  - strobe/sof/eof=0; data_pins holds the last byte.
  - After exactly GAP_CYCLES cycles, idx increments and the state returns to SEND.
- FINISH: pulse done for 1 cycle, clear busy, ctrl_pins=0, go to IDLE. start is accepted again in the next cycle (IDLE).
- core_busy is checked only in WAIT_RDY. A rise of core_busy mid-frame does not stall or abort the frame.
- Registered outputs; no combinational path from inputs to any output.
- Latency:
  - Accepted start with core_busy=0: first strobe 2 cycles after the start edge (IDLE to WAIT_RDY to SEND).
  - Frame length (first to last strobe): (N-1)*(GAP_CYCLES+1)+1 cycles, where N is the byte count.
- Reset mid-frame: outputs return to 0 immediately; no done pulse; the receiver sees the frame truncated (no eof).
- done and timeout are never asserted in the same cycle.

Optional Feature:
- Macro: PARAM_TX_CSUM_EN.
- Defined:
  - A 9th byte (idx 8) is appended, equal to the XOR of the 8 data bytes.
  - eof moves to the checksum byte; N=9.
  - The checksum byte follows the same GAP pacing as data bytes.
- Undefined: N=8, eof on idx 7, no checksum logic synthesised.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> all outputs 0, no strobe for 5 cycles after release with start=0.
- Basic frame, GAP_CYCLES=1, a0=0x11223344, a1=0xA5A5_0F0F, core_busy=0:
  - Strobed bytes are 44,33,22,11,0F,0F,A5,A5.
  - sof on first byte, eof on last byte.
  - Strobes on every 2nd cycle; done 1 cycle after the last strobe.
- Busy wait: core_busy=1 for 10 cycles after start, then 0 -> first strobe exactly 1 cycle after core_busy falls; frame identical to the basic frame.
- Timeout, BUSY_TIMEOUT=20: core_busy held 1 -> timeout pulse after 20 wait cycles, no strobe, busy=0; a following start with core_busy=0 sends normally.
- Back-to-back and ignored start:
  - start held high through a frame -> the second frame begins only after done, using the a0/a1 captured at re-acceptance.
  - Changing a0 mid-frame does not alter the bytes being sent.
- PARAM_TX_CSUM_EN, GAP_CYCLES=0, a0=0x01020304, a1=0x10203040 -> 9 consecutive strobes, last byte 0x44, eof only on byte 9; reset asserted at byte 5 -> outputs 0 immediately, no done.
